// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared opcodes and state encodings for the debug sequencer
package debug_pkg;

  typedef enum logic [1:0] {
    OP_RUN   = 2'd0,
    OP_HALT  = 2'd1,
    OP_STEP  = 2'd2,
    OP_CLEAR = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN_REQ   = 3'd1,
    S_RUNNING   = 3'd2,
    S_HALT_REQ  = 3'd3,
    S_STEP_HI   = 3'd4,
    S_STEP_GAP1 = 3'd5,
    S_STEP_GAP2 = 3'd6
  } state_e;

endpackage

// File: rtl/bp_compare.sv
// rtl/bp_compare.sv - enabled equality compare of program counter against breakpoint
module bp_compare #(
  parameter int PC_WIDTH = 16
) (
  input  logic                en,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] addr,
  output logic                match
);

  assign match = en && (pc == addr);

endmodule

// File: rtl/debug_sequencer.sv
// rtl/debug_sequencer.sv - host command sequencer driving run/halt/step requests
module debug_sequencer
  import debug_pkg::*;
#(
  parameter int PC_WIDTH  = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CNT_WIDTH-1:0] cmd_arg,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 bp_en,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  output logic                 run,
  output logic                 halt,
  output logic                 step,
  output logic                 busy,
  output logic                 done,
  output logic                 bp_hit,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] steps_left
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e  state, state_nxt;
  cmd_op_e op;
  logic    accept, bp_match;
  logic    fin, set_bp, clr_bp, set_err, clr_status, load_steps;

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = (state == S_IDLE) || (state == S_RUNNING);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != S_IDLE);

  bp_compare #(.PC_WIDTH(PC_WIDTH)) u_bp_compare (
    .en   (bp_en),
    .pc   (pc),
    .addr (bp_addr),
    .match(bp_match)
  );

  always_comb begin
    state_nxt  = state;
    fin        = 1'b0;
    set_bp     = 1'b0;
    clr_bp     = 1'b0;
    set_err    = 1'b0;
    clr_status = 1'b0;
    load_steps = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_RUN: begin
              clr_bp    = 1'b1;
              state_nxt = S_RUN_REQ;
            end
            OP_HALT: fin = 1'b1;
            OP_STEP: begin
              clr_bp     = 1'b1;
              load_steps = 1'b1;
              if (cmd_arg != '0) state_nxt = S_STEP_HI;
              else               fin       = 1'b1;
            end
            OP_CLEAR: begin
              clr_status = 1'b1;
              fin        = 1'b1;
            end
          endcase
        end
      end
      S_RUN_REQ: state_nxt = S_RUNNING;
      S_RUNNING: begin
        // Anything other than HALT while running is dropped and flagged.
        if (accept && op != OP_HALT) set_err = 1'b1;
        if (bp_match) begin
          set_bp    = 1'b1;
          fin       = 1'b1;
          state_nxt = S_HALT_REQ;
        end else if (accept && op == OP_HALT) begin
          fin       = 1'b1;
          state_nxt = S_HALT_REQ;
        end
      end
      S_HALT_REQ:  state_nxt = S_IDLE;
      S_STEP_HI:   state_nxt = S_STEP_GAP1;
      S_STEP_GAP1: state_nxt = S_STEP_GAP2;
      S_STEP_GAP2: begin
        if (steps_left == '0 || bp_match) begin
          fin       = 1'b1;
          set_bp    = bp_match;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_STEP_HI;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      run        <= 1'b0;
      halt       <= 1'b0;
      step       <= 1'b0;
      done       <= 1'b0;
      bp_hit     <= 1'b0;
      err        <= 1'b0;
      steps_left <= '0;
    end else begin
      state <= state_nxt;
      // Pulses are flopped from the next state so they align with the state they name.
      run   <= (state_nxt == S_RUN_REQ);
      halt  <= (state_nxt == S_HALT_REQ);
      step  <= (state_nxt == S_STEP_HI);
      done  <= fin;
      if (clr_status) begin
        bp_hit <= 1'b0;
        err    <= 1'b0;
      end else begin
        if (clr_bp)      bp_hit <= 1'b0;
        else if (set_bp) bp_hit <= 1'b1;
        if (set_err)     err    <= 1'b1;
      end
      if (load_steps)
        steps_left <= cmd_arg;
      else if (state == S_STEP_HI && steps_left != '0)
        steps_left <= steps_left - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_debug_sequencer.sv
// tb/tb_debug_sequencer.sv - scoreboard bench for debug_sequencer with a processor model
module tb_debug_sequencer;
  import debug_pkg::*;

  localparam int PW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [CW-1:0] cmd_arg = '0;
  logic [PW-1:0] pc = '0;
  logic          bp_en = 1'b0;
  logic [PW-1:0] bp_addr = '0;
  logic          run, halt, step, busy, done, bp_hit, err;
  logic [CW-1:0] steps_left;

  debug_sequencer #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
    .run(run), .halt(halt), .step(step), .busy(busy), .done(done),
    .bp_hit(bp_hit), .err(err), .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    int runs; int halts; int steps;
    int bp; int er; int chk_sl; int sl;
  } exp_t;

  exp_t expq[$];
  int   checks = 0, errors = 0;
  int   done_count = 0;
  int   n_run = 0, n_halt = 0, n_step = 0, since_step = 0, seen_step = 0;
  int   m_bp_hit = 0, m_err = 0;
  bit   proc_running = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Processor model: pc advances every cycle while running and once per step pulse.
  initial forever begin
    @(posedge clk);
    #1;
    if (reset) proc_running = 1'b0;
    else begin
      if (proc_running) pc = pc + 16'd1;
      if (step) pc = pc + 16'd1;
      if (run)  proc_running = 1'b1;
      if (halt) proc_running = 1'b0;
    end
  end

  // Monitor: counts pulses and checks each completed sequence against the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset) begin
      n_run = 0; n_halt = 0; n_step = 0; seen_step = 0; since_step = 0;
    end else begin
      check("pulse_exclusive", (int'(run) + int'(halt) + int'(step)) <= 1 ? 1 : 0, 1);
      since_step++;
      if (run)  n_run++;
      if (halt) n_halt++;
      if (step) begin
        check("ready_low_in_step", int'(cmd_ready), 0);
        if (seen_step != 0) check("step_period", since_step, 3);
        seen_step = 1;
        since_step = 0;
        n_step++;
      end
      if (done) begin
        done_count++;
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no done");
        end else begin
          e = expq.pop_front();
          check("run_pulses", n_run, e.runs);
          check("halt_pulses", n_halt, e.halts);
          check("step_pulses", n_step, e.steps);
          check("bp_hit", int'(bp_hit), e.bp);
          check("err", int'(err), e.er);
          if (e.chk_sl != 0) check("steps_left", int'(steps_left), e.sl);
        end
        n_run = 0; n_halt = 0; n_step = 0; seen_step = 0;
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input int arg);
    bit ok = 1'b0;
    cmd_op = op; cmd_arg = CW'(arg); cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout: got cmd_ready=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic wait_done(input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (done_count >= target) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL done_timeout: got done_count=%0d expected %0d", done_count, target);
    end
  endtask

  task automatic do_run(input bit use_bp, input int k, input int delay, input int n_illegal,
                        input logic [PW-1:0] pc0);
    exp_t e;
    int   target;
    logic [1:0] ill;
    pc      = pc0;
    bp_en   = use_bp ? 1'b1 : 1'($urandom_range(0, 1));
    bp_addr = use_bp ? pc0 + PW'(k) : pc0 - 16'd1;
    m_bp_hit = use_bp ? 1 : 0;
    if (n_illegal > 0) m_err = 1;
    e = '{runs: 1, halts: 1, steps: 0, bp: m_bp_hit, er: m_err, chk_sl: 0, sl: 0};
    expq.push_back(e);
    target = done_count + 1;
    send_cmd(OP_RUN, 0);
    if (!use_bp) begin
      for (int i = 0; i < n_illegal; i++) begin
        case ($urandom_range(0, 2))
          0:       ill = OP_RUN;
          1:       ill = OP_STEP;
          default: ill = OP_CLEAR;
        endcase
        send_cmd(ill, int'($urandom_range(1, 5)));
      end
      repeat (delay) @(posedge clk);
      #1;
      send_cmd(OP_HALT, 0);
    end
    wait_done(target);
  endtask

  task automatic do_step(input int n, input bit use_bp, input int k, input logic [PW-1:0] pc0);
    exp_t e;
    int   target, p, hit;
    pc      = pc0;
    bp_en   = use_bp ? 1'b1 : 1'($urandom_range(0, 1));
    bp_addr = use_bp ? pc0 + PW'(k) : pc0 - 16'd1;
    p   = (use_bp && k <= n) ? k : n;
    hit = (use_bp && n > 0 && k <= n) ? 1 : 0;
    m_bp_hit = hit;
    e = '{runs: 0, halts: 0, steps: p, bp: hit, er: m_err, chk_sl: 1, sl: n - p};
    expq.push_back(e);
    target = done_count + 1;
    send_cmd(OP_STEP, n);
    wait_done(target);
  endtask

  task automatic do_idle(input logic [1:0] op);
    exp_t e;
    int   target;
    if (op == OP_CLEAR) begin
      m_bp_hit = 0; m_err = 0;
    end
    e = '{runs: 0, halts: 0, steps: 0, bp: m_bp_hit, er: m_err, chk_sl: 0, sl: 0};
    expq.push_back(e);
    target = done_count + 1;
    send_cmd(op, 0);
    wait_done(target);
  endtask

  task automatic reset_mid_step();
    int  dc;
    bit  seen = 1'b0;
    bp_en = 1'b0;
    pc = 16'($urandom);
    send_cmd(OP_STEP, 4);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (step) seen = 1'b1;
    end
    check("first_step_seen", int'(seen), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    check("rst_outputs", int'({run, halt, step, busy, done, bp_hit, err}), 0);
    check("rst_steps_left", int'(steps_left), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_bp_hit = 0; m_err = 0;
    dc = done_count;
    repeat (20) @(posedge clk);
    #1;
    check("no_pulse_after_rst", n_run + n_halt + n_step, 0);
    check("no_done_after_rst", done_count, dc);
    check("idle_after_rst", int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'({run, halt, step, busy, done, bp_hit, err}), 0);
    check("reset_steps_left", int'(steps_left), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready", int'(cmd_ready), 1);
    check("reset_busy", int'(busy), 0);
    @(posedge clk);
    #1;

    do_run(1'b0, 0, 10, 0, 16'($urandom));
    do_run(1'b1, 16, 0, 0, 16'h0030);
    check("bp_stop_pc_0040", int'(bp_addr), 16'h0040);
    do_step(3, 1'b0, 0, 16'($urandom));
    do_step(5, 1'b1, 2, 16'($urandom));
    do_step(0, 1'b0, 0, 16'($urandom));
    do_idle(OP_HALT);
    do_run(1'b0, 0, 5, 1, 16'($urandom));
    do_idle(OP_CLEAR);
    reset_mid_step();
    do_step(2, 1'b0, 0, 16'($urandom));

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: do_run(1'b1, int'($urandom_range(1, 20)), 0, 0, 16'($urandom));
        1: do_run(1'b0, 0, int'($urandom_range(1, 12)), int'($urandom_range(0, 2)), 16'($urandom));
        2, 3: do_step(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(1, 8)), 16'($urandom));
        default: do_idle($urandom_range(0, 1) != 0 ? OP_HALT : OP_CLEAR);
      endcase
    end

    repeat (5) @(posedge clk);
    check("scoreboard_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
